tff_3bits: RTL and testbench
============================

// Module: tff_3bits
// PURPOSE
//   Bank of three independent toggle flip-flops driven by board push-buttons, with results on LEDs.
//   btn[2:0] are the T inputs. btn[3] is the reset. led[2:0] are the flip-flop states. led[3] is a run indicator.
//   Top-level board block. One clock domain, no handshakes.
// PARAMETERS
//   SYNC_STAGES  0  register stages on btn[2:0] before T use (0 = sample directly; 0..3 legal)
//   EDGE_MODE    0  0: toggle on every clock with T=1; 1: toggle only on T 0->1 transition
// PORTS
//   sysclk  in   1  system clock; all state updates on posedge
//   btn     in   4  btn[3] = synchronous active-low reset; btn[2:0] = T inputs for bits 2..0
//   led     out  4  led[2:0] = TFF states; led[3] = registered run flag (1 when out of reset)
// BEHAVIOUR
//   - One clock (sysclk), rising edge only. Reset is btn[3]: synchronous, active-low, sampled on posedge sysclk.
//   - Reset (btn[3]==0 at posedge):
//       led[3:0] <= 4'b0000; all sync-stage and edge-history registers <= 0.
//       T inputs are ignored that cycle. Reset always overrides toggling.
//   - Run (btn[3]==1 at posedge): led[3] <= 1.
//   - T source t[i]: btn[i] delayed by SYNC_STAGES flops.
//       SYNC_STAGES=0 -> t[i] = btn[i] combinationally.
//   - EDGE_MODE=0: led[i] <= led[i] ^ t[i] for i in 0..2.
//       Constant T=1 toggles every cycle; T=0 holds.
//   - EDGE_MODE=1: led[i] <= led[i] ^ (t[i] & ~t_prev[i]). t_prev[i] updates every run cycle.
//       After reset t_prev=0, so T already high at first run edge counts as a rising edge.
//   - Bits are fully independent; any combination of T bits may toggle in the same cycle.
//   - Latency, EDGE_MODE=0, SYNC_STAGES=0: T sampled at edge k changes led at edge k (visible after k).
//       Each sync stage adds one cycle.
//   - Reset mid-run: the next posedge with btn[3]==0 clears led to 0000 whatever T is.
//       First run edge after release: applies T, sets led[3]=1.
//   - Outputs are registered only: no combinational path btn->led.
//   - No X propagation out of reset: every register has a reset value.
// TESTING (defaults SYNC_STAGES=0, EDGE_MODE=0 unless noted)
//   1. btn=0000 for 2 clks -> led=0000. btn=0111 then held for 1 clk -> led=0000 (reset wins over T).
//   2. From reset, btn=1001 for 3 clks -> led=1001, 1000, 1001 (bit0 toggles every clk).
//   3. From reset, btn=1111 one clk -> 1111; btn=1010 one clk -> 1101; btn=1000 two clks -> 1101 held.
//   4. Running with led=1101, btn=0xxx one clk -> led=0000; next btn=1100 -> led=1100.
//   5. EDGE_MODE=1, from reset btn=1001 for 3 clks -> led=1001,1001,1001; btn=1000 then 1001 -> 1001, then 1000.
//   6. SYNC_STAGES=2, from reset btn=1001 held -> led=1000, 1000, 1001, 1000 (T reaches TFF 2 clks late).

Source files
------------

// File: rtl/tff_3bits.sv
// rtl/tff_3bits.sv - three independent toggle flip-flops on push-buttons, states and run flag on LEDs
// btn[3] is a synchronous active-low reset; T inputs optionally pass through a register chain first.
module tff_3bits #(
   parameter int SYNC_STAGES = 0,
   parameter int EDGE_MODE   = 0
) (
   input  logic       sysclk,
   input  logic [3:0] btn,
   output logic [3:0] led
);

   logic       resetn;
   logic [2:0] t;
   logic [2:0] toggle;
   logic [2:0] tff_q, tff_d;
   logic [2:0] t_prev_q, t_prev_d;
   logic       run_q, run_d;

   assign resetn = btn[3];

   // T source: raw buttons, or the tail of a SYNC_STAGES-deep register chain.
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign t = btn[2:0];
      end else begin : g_sync
         logic [2:0] sync_q [SYNC_STAGES];
         logic [2:0] sync_d [SYNC_STAGES];

         always_comb begin
            sync_d[0] = btn[2:0];
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sync_d[i] = sync_q[i-1];
            end
         end

         always_ff @(posedge sysclk) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
               if (!resetn) begin
                  sync_q[i] <= 3'b000;
               end else begin
                  sync_q[i] <= sync_d[i];
               end
            end
         end

         assign t = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_comb begin
      toggle   = 3'b000;
      tff_d    = tff_q;
      t_prev_d = t;
      run_d    = 1'b1;
      // Edge mode only counts a 0->1 step of T; history starts at 0 so a held button counts once.
      if (EDGE_MODE != 0) begin
         toggle = t & ~t_prev_q;
      end else begin
         toggle = t;
      end
      tff_d = tff_q ^ toggle;
   end

   always_ff @(posedge sysclk) begin
      if (!resetn) begin
         tff_q    <= 3'b000;
         t_prev_q <= 3'b000;
         run_q    <= 1'b0;
      end else begin
         tff_q    <= tff_d;
         t_prev_q <= t_prev_d;
         run_q    <= run_d;
      end
   end

   assign led = {run_q, tff_q};

endmodule

// File: tb/tb_tff_3bits.sv
// tb/tb_tff_3bits.sv - self-checking bench for tff_3bits across four parameter sets
// Directed board sequences plus random buttons compared with a history-based reference model.
module tb_tff_3bits;

   logic       sysclk;
   logic [3:0] btn;
   logic [3:0] led_o [4];

   int checks;
   int errors;

   int         st [4];
   int         em [4];
   logic [3:0] mled  [4];
   logic [2:0] mprev [4];
   logic [2:0] hist  [4][4];

   tff_3bits #(.SYNC_STAGES(0), .EDGE_MODE(0)) dut_a (.sysclk(sysclk), .btn(btn), .led(led_o[0]));
   tff_3bits #(.SYNC_STAGES(0), .EDGE_MODE(1)) dut_b (.sysclk(sysclk), .btn(btn), .led(led_o[1]));
   tff_3bits #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_c (.sysclk(sysclk), .btn(btn), .led(led_o[2]));
   tff_3bits #(.SYNC_STAGES(3), .EDGE_MODE(1)) dut_d (.sysclk(sysclk), .btn(btn), .led(led_o[3]));

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: T at a run edge is the button value sampled st[d] run edges earlier
   // (zero if a reset intervened), so keep a short history of sampled buttons.
   task automatic model_edge(input logic [3:0] b);
      logic [2:0] t;
      logic [2:0] tg;
      for (int d = 0; d < 4; d++) begin
         if (b[3] == 1'b0) begin
            mled[d]  = 4'b0000;
            mprev[d] = 3'b000;
            for (int k = 0; k < 4; k++) hist[d][k] = 3'b000;
         end else begin
            t  = (st[d] == 0) ? b[2:0] : hist[d][st[d]-1];
            tg = (em[d] != 0) ? (t & ~mprev[d]) : t;
            mprev[d] = t;
            mled[d]  = {1'b1, mled[d][2:0] ^ tg};
            for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = b[2:0];
         end
      end
   endtask

   task automatic step(input logic [3:0] b);
      btn = b;
      @(posedge sysclk);
      model_edge(b);
      #1;
      for (int d = 0; d < 4; d++) begin
         check($sformatf("model_dut%0d", d), led_o[d], mled[d]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      st = '{0, 0, 2, 3};
      em = '{0, 1, 0, 1};
      for (int d = 0; d < 4; d++) begin
         mled[d]  = 4'b0000;
         mprev[d] = 3'b000;
         for (int k = 0; k < 4; k++) hist[d][k] = 3'b000;
      end
      btn = 4'b0000;

      // Reset holds, and wins over T.
      step(4'b0000); check("rst1", led_o[0], 4'b0000);
      step(4'b0000); check("rst2", led_o[0], 4'b0000);
      step(4'b0111); check("rst_over_t", led_o[0], 4'b0000);

      // Bit 0 toggles every clock with T held.
      step(4'b0000);
      step(4'b1001); check("t0_a", led_o[0], 4'b1001);
      step(4'b1001); check("t0_b", led_o[0], 4'b1000);
      step(4'b1001); check("t0_c", led_o[0], 4'b1001);

      // Mixed bits, then hold.
      step(4'b0000);
      step(4'b1111); check("mix_all", led_o[0], 4'b1111);
      step(4'b1010); check("mix_b1", led_o[0], 4'b1101);
      step(4'b1000); check("hold_a", led_o[0], 4'b1101);
      step(4'b1000); check("hold_b", led_o[0], 4'b1101);

      // Reset mid-run, then first run edge applies T.
      step(4'b0111); check("mid_rst", led_o[0], 4'b0000);
      step(4'b1100); check("post_rst", led_o[0], 4'b1100);

      // Edge mode: held T toggles once.
      step(4'b0000);
      step(4'b1001); check("edge_a", led_o[1], 4'b1001);
      step(4'b1001); check("edge_b", led_o[1], 4'b1001);
      step(4'b1001); check("edge_c", led_o[1], 4'b1001);
      step(4'b1000); check("edge_fall", led_o[1], 4'b1001);
      step(4'b1001); check("edge_rise", led_o[1], 4'b1000);

      // Two sync stages delay T by two clocks.
      step(4'b0000);
      step(4'b1001); check("sync_a", led_o[2], 4'b1000);
      step(4'b1001); check("sync_b", led_o[2], 4'b1000);
      step(4'b1001); check("sync_c", led_o[2], 4'b1001);
      step(4'b1001); check("sync_d", led_o[2], 4'b1000);

      // Random buttons with occasional reset pulses.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] b;
         b[2:0] = 3'($urandom);
         b[3]   = ($urandom_range(0, 15) != 0);
         step(b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
